// File: rtl/itch_pkg.sv
// Shared ITCH message definitions: order/side/stock encodings, wire byte constants
// and frame lengths, used by both the encoder and the parser.
package itch_pkg;

    typedef enum logic [1:0] {
        ORD_ADD     = 2'd0,
        ORD_CANCEL  = 2'd1,
        ORD_EXECUTE = 2'd2,
        ORD_BAD     = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STK_AAPL  = 2'd0,
        STK_AMZN  = 2'd1,
        STK_MSFT  = 2'd2,
        STK_GOOGL = 2'd3
    } stock_t;

    localparam logic [7:0] MSG_ADD     = 8'h41;
    localparam logic [7:0] MSG_CANCEL  = 8'h58;
    localparam logic [7:0] MSG_EXECUTE = 8'h45;

    localparam logic [7:0] SIDE_BUY  = 8'h42;
    localparam logic [7:0] SIDE_SELL = 8'h53;

    localparam logic [63:0] ASCII_AAPL  = 64'h4141504C20202020;
    localparam logic [63:0] ASCII_AMZN  = 64'h414D5A4E20202020;
    localparam logic [63:0] ASCII_MSFT  = 64'h4D53465420202020;
    localparam logic [63:0] ASCII_GOOGL = 64'h474F4F474C202020;

    localparam logic [2:0] LEN_ADD     = 3'd7;
    localparam logic [2:0] LEN_EXECUTE = 3'd4;
    localparam logic [2:0] LEN_CANCEL  = 3'd3;

    typedef struct packed {
        order_t      otype;
        stock_t      stock;
        trade_t      side;
        logic [31:0] oid;
        logic [31:0] px;
        logic [15:0] qty;
        logic [31:0] ts;
    } order_rec_t;

    function automatic logic [2:0] frame_len(order_t t);
        case (t)
            ORD_ADD:     return LEN_ADD;
            ORD_CANCEL:  return LEN_CANCEL;
            ORD_EXECUTE: return LEN_EXECUTE;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] msg_byte(order_t t);
        case (t)
            ORD_ADD:     return MSG_ADD;
            ORD_CANCEL:  return MSG_CANCEL;
            ORD_EXECUTE: return MSG_EXECUTE;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/itch_symbol_rom.sv
// Stock code to 8-byte space-padded ASCII ticker lookup (purely combinational).
module itch_symbol_rom
    import itch_pkg::*;
(
    input  logic [1:0]  stock,
    output logic [63:0] ascii
);

    always_comb begin
        ascii = ASCII_AAPL;
        case (stock_t'(stock))
            STK_AAPL:  ascii = ASCII_AAPL;
            STK_AMZN:  ascii = ASCII_AMZN;
            STK_MSFT:  ascii = ASCII_MSFT;
            STK_GOOGL: ascii = ASCII_GOOGL;
            default:   ascii = ASCII_AAPL;
        endcase
    end

endmodule

// File: rtl/itch_encoder.sv
// Order event to ITCH word-stream encoder: captures an order with a timestamp,
// then streams 3/4/7 big-endian 32-bit beats over valid/ready.
module itch_encoder
    import itch_pkg::*;
#(
    parameter int         REG_WIDTH = 32,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_order_valid,
    output logic                 o_order_ready,
    input  logic [1:0]           i_order_type,
    input  logic [1:0]           i_stock_symbol,
    input  logic [31:0]          i_order_id,
    input  logic [31:0]          i_price,
    input  logic [15:0]          i_quantity,
    input  logic                 i_trade_type,
    output logic [REG_WIDTH-1:0] o_word,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_word_last,
    output logic                 o_err
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t         state, state_n;
    logic [31:0]    ts;
    order_rec_t     in_rec, cap, src;
    logic [2:0]     beat, beat_n;
    logic [63:0]    sym_ascii;
    logic           accept_ok, accept_bad, frame_done, beat_done;
    logic [REG_WIDTH-1:0] word_n;
    logic [7:0]     type_b, side_b;
    logic [31:0]    sh, px;
    logic [63:0]    stk;

    always_comb begin
        in_rec.otype = order_t'(i_order_type);
        in_rec.stock = stock_t'(i_stock_symbol);
        in_rec.side  = trade_t'(i_trade_type);
        in_rec.oid   = i_order_id;
        in_rec.px    = i_price;
        in_rec.qty   = i_quantity;
        in_rec.ts    = ts;
    end

    // Beat 0 is built straight from the inputs so it can be registered on the accept edge.
    assign src       = (state == ST_IDLE) ? in_rec : cap;
    assign beat_done = o_word_valid & i_word_ready;
    assign beat_n    = accept_ok ? 3'd0 : beat + 3'd1;

    itch_symbol_rom u_rom (
        .stock (src.stock),
        .ascii (sym_ascii)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n       = state;
        accept_ok     = 1'b0;
        accept_bad    = 1'b0;
        frame_done    = 1'b0;
        o_order_ready = (state == ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (i_order_valid) begin
                    if (order_t'(i_order_type) == ORD_BAD) begin
                        accept_bad = 1'b1;
                    end else begin
                        accept_ok = 1'b1;
                        state_n   = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (beat_done && o_word_last) begin
                    frame_done = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Fields absent from a shorter message type go out as PAD.
    always_comb begin
        type_b = msg_byte(src.otype);
        side_b = (src.otype == ORD_ADD) ?
                 ((src.side == TRADE_SELL) ? SIDE_SELL : SIDE_BUY) : PAD_BYTE;
        sh     = (src.otype == ORD_CANCEL) ? {4{PAD_BYTE}} : {16'h0000, src.qty};
        stk    = (src.otype == ORD_ADD) ? sym_ascii : {8{PAD_BYTE}};
        px     = (src.otype == ORD_ADD) ? src.px : {4{PAD_BYTE}};
        case (beat_n)
            3'd0:    word_n = {type_b, src.ts[31:8]};
            3'd1:    word_n = {src.ts[7:0], src.oid[31:8]};
            3'd2:    word_n = {src.oid[7:0], side_b, sh[31:16]};
            3'd3:    word_n = {sh[15:0], stk[63:48]};
            3'd4:    word_n = stk[47:16];
            3'd5:    word_n = {stk[15:0], px[31:16]};
            3'd6:    word_n = {px[15:0], PAD_BYTE, PAD_BYTE};
            default: word_n = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts           <= '0;
            cap          <= '0;
            beat         <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_word_last  <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            ts    <= ts + 32'd1;
            o_err <= accept_bad;
            if (accept_ok) begin
                cap          <= in_rec;
                beat         <= '0;
                o_word       <= word_n;
                o_word_valid <= 1'b1;
                o_word_last  <= 1'b0;
            end else if (frame_done) begin
                beat         <= '0;
                o_word       <= '0;
                o_word_valid <= 1'b0;
                o_word_last  <= 1'b0;
            end else if (beat_done) begin
                beat        <= beat_n;
                o_word      <= word_n;
                o_word_last <= (beat_n == frame_len(cap.otype) - 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_itch_encoder.sv
// Scoreboard bench for itch_encoder: a byte-stream reference model queues expected beats.
module tb_itch_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_order_valid = 1'b0;
    logic        o_order_ready;
    logic [1:0]  i_order_type = '0;
    logic [1:0]  i_stock_symbol = '0;
    logic [31:0] i_order_id = '0;
    logic [31:0] i_price = '0;
    logic [15:0] i_quantity = '0;
    logic        i_trade_type = 1'b0;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        i_word_ready = 1'b1;
    logic        o_word_last;
    logic        o_err;

    itch_encoder dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_order_valid  (i_order_valid),
        .o_order_ready  (o_order_ready),
        .i_order_type   (i_order_type),
        .i_stock_symbol (i_stock_symbol),
        .i_order_id     (i_order_id),
        .i_price        (i_price),
        .i_quantity     (i_quantity),
        .i_trade_type   (i_trade_type),
        .o_word         (o_word),
        .o_word_valid   (o_word_valid),
        .i_word_ready   (i_word_ready),
        .o_word_last    (o_word_last),
        .o_err          (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] w; logic last; } beat_t;
    beat_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    bit          rdy_toggle = 1'b0;
    logic [31:0] cyc = '0;
    logic [31:0] ts_off = '0;

    always @(posedge i_clk) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] sym(input logic [1:0] s);
        case (s)
            2'd0:    return 64'h4141504C20202020;
            2'd1:    return 64'h414D5A4E20202020;
            2'd2:    return 64'h4D53465420202020;
            default: return 64'h474F4F474C202020;
        endcase
    endfunction

    // Reference: lay out the full 28-byte message, then cut it to the type's length.
    task automatic push_frame(input logic [1:0] typ, input logic [1:0] stk,
                              input logic [31:0] oid, input logic [31:0] px,
                              input logic [15:0] qty, input logic sell, input logic [31:0] ts);
        logic [7:0]  b [0:27];
        logic [63:0] s;
        logic [31:0] sh, p;
        logic [7:0]  tb, sideb;
        int          len;
        beat_t       e;
        case (typ)
            2'd0:    begin tb = 8'h41; len = 7; end
            2'd1:    begin tb = 8'h58; len = 3; end
            default: begin tb = 8'h45; len = 4; end
        endcase
        sideb = (typ == 2'd0) ? (sell ? 8'h53 : 8'h42) : 8'h00;
        sh    = (typ == 2'd1) ? 32'h0 : {16'h0, qty};
        s     = (typ == 2'd0) ? sym(stk) : 64'h0;
        p     = (typ == 2'd0) ? px : 32'h0;
        b[0]  = tb;
        for (int i = 0; i < 4; i++) begin
            b[1+i]  = ts[31-8*i -: 8];
            b[5+i]  = oid[31-8*i -: 8];
            b[10+i] = sh[31-8*i -: 8];
            b[22+i] = p[31-8*i -: 8];
        end
        b[9] = sideb;
        for (int i = 0; i < 8; i++) b[14+i] = s[63-8*i -: 8];
        b[26] = 8'h00;
        b[27] = 8'h00;
        for (int w = 0; w < len; w++) begin
            e.w    = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            e.last = (w == len - 1);
            sb.push_back(e);
        end
    endtask

    // Called at negedge+1; returns at negedge+1 after the accept edge.
    task automatic send_order(input logic [1:0] typ, input logic [1:0] stk,
                              input logic [31:0] oid, input logic [31:0] px,
                              input logic [15:0] qty, input logic sell);
        int n = 0;
        while (o_order_ready !== 1'b1 && n < 200) begin
            @(negedge i_clk); #1;
            n++;
        end
        chk("order_ready_wait", n < 200, 1);
        i_order_type   = typ;
        i_stock_symbol = stk;
        i_order_id     = oid;
        i_price        = px;
        i_quantity     = qty;
        i_trade_type   = sell;
        i_order_valid  = 1'b1;
        if (typ != 2'd3) push_frame(typ, stk, oid, px, qty, sell, cyc + ts_off);
        @(negedge i_clk); #1;
        i_order_valid  = 1'b0;
        i_order_type   = 2'($urandom);
        i_stock_symbol = 2'($urandom);
        i_order_id     = $urandom;
        i_price        = $urandom;
        i_quantity     = 16'($urandom);
        i_trade_type   = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || o_word_valid) && n < 500) begin
            @(negedge i_clk); #1;
            n++;
        end
        chk("drain_wait", n < 500, 1);
    endtask

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_word_ready = rdy_toggle ? ~i_word_ready : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every transfer and checks stall/idle rules.
    initial begin
        logic [31:0] prev_w;
        logic        prev_last, prev_stall, prev_lastx;
        beat_t       e;
        prev_w = '0; prev_last = 1'b0; prev_stall = 1'b0; prev_lastx = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (prev_stall) begin
                    chk("hold_valid", o_word_valid, 1);
                    chk("hold_word", o_word, prev_w);
                    chk("hold_last", o_word_last, prev_last);
                end
                if (prev_lastx) begin
                    chk("ready_after_last", o_order_ready, 1);
                    chk("idle_gap", o_word_valid, 0);
                end
                if (o_word_valid && i_word_ready) begin
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("word", o_word, e.w);
                        chk("last", o_word_last, e.last);
                    end
                    beats_seen++;
                end
                prev_stall = o_word_valid && !i_word_ready;
                prev_w     = o_word;
                prev_last  = o_word_last;
                prev_lastx = o_word_valid && i_word_ready && o_word_last;
            end else begin
                prev_stall = 1'b0;
                prev_lastx = 1'b0;
            end
        end
    end

    initial begin
        int base, n;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_valid", o_word_valid, 0);
        chk("rst_word", o_word, 0);
        chk("rst_last", o_word_last, 0);
        chk("rst_err", o_err, 0);
        i_rst_n = 1'b1;
        ts_off  = 32'h0 - cyc;
        #1;
        chk("rst_ready", o_order_ready, 1);

        // ADD AMZN SELL, ready high
        send_order(2'd0, 2'd1, 32'h000003BA, 32'h0000BABB, 16'h01BB, 1'b1);
        chk("add_valid_n1", o_word_valid, 1);
        chk("add_type_byte", o_word[31:24], 8'h41);
        wait_drain();

        send_order(2'd1, 2'd3, 32'h12345678, 32'hDEADBEEF, 16'hFFFF, 1'b0);
        wait_drain();
        send_order(2'd2, 2'd2, 32'hCAFE0001, 32'h11112222, 16'h0064, 1'b1);
        wait_drain();

        // Stalling downstream, back-to-back frames
        rdy_toggle = 1'b1;
        send_order(2'd0, 2'd0, 32'hA5A5A5A5, 32'h01020304, 16'h7FFF, 1'b0);
        for (int k = 0; k < 4; k++)
            send_order(2'($urandom_range(0, 2)), 2'($urandom), $urandom, $urandom,
                       16'($urandom), 1'($urandom));
        wait_drain();
        rdy_toggle = 1'b0;
        @(negedge i_clk); #1;

        // Illegal type
        send_order(2'd3, 2'd0, 32'h1, 32'h2, 16'h3, 1'b0);
        chk("bad_err_pulse", o_err, 1);
        chk("bad_no_valid", o_word_valid, 0);
        chk("bad_stay_idle", o_order_ready, 1);
        @(negedge i_clk); #1;
        chk("bad_err_clear", o_err, 0);
        chk("bad_no_valid2", o_word_valid, 0);
        send_order(2'd0, 2'd2, 32'h00000042, 32'h00010203, 16'h0010, 1'b0);
        wait_drain();

        // Reset during beat 4
        base = beats_seen;
        send_order(2'd0, 2'd3, 32'h0BADF00D, 32'h99887766, 16'h0ABC, 1'b1);
        n = 0;
        while (beats_seen < base + 4 && n < 100) begin
            @(negedge i_clk); #1;
            n++;
        end
        chk("beat4_wait", n < 100, 1);
        @(posedge i_clk); #1;
        chk("beat4_word", o_word, sb.size() > 0 ? sb[0].w : 32'hX);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_word_valid, 0);
        chk("midrst_last", o_word_last, 0);
        sb.delete();
        repeat (2) @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        ts_off  = 32'h0 - cyc;
        #1;
        chk("midrst_ready", o_order_ready, 1);
        send_order(2'd1, 2'd0, 32'h87654321, 32'h0, 16'h1234, 1'b1);
        wait_drain();

        // Timestamp wrap
        force dut.ts = 32'hFFFFFFFF;
        release dut.ts;
        ts_off = 32'hFFFFFFFF - cyc;
        @(negedge i_clk); #1;
        send_order(2'd1, 2'd1, 32'h00C0FFEE, 32'h0, 16'h0, 1'b0);
        wait_drain();

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
